pio_write_arbiter: RTL and testbench
====================================

PIO_WRITE_ARBITER -- requirements
Module: pio_write_arbiter

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 4: minimum idle cycles after each completed transaction before the next grant (0..255).
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req  input  2  per-requester write request; held high until matching ack.
REQ-005 SHALL have port wdata0  input  32  requester 0 write data.
REQ-006 SHALL have port wdata1  input  32  requester 1 write data.
REQ-007 SHALL have port ack  output  2  one-cycle completion pulse per requester.
REQ-008 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-009 SHALL have port m_chipselect  output  1  Avalon-MM slave select to the PIO.
REQ-010 SHALL have port m_write_n  output  1  Avalon-MM write strobe, active-low.
REQ-011 SHALL have port m_address  output  2  Avalon-MM address; always 0.
REQ-012 SHALL have port m_writedata  output  32  Avalon-MM write data.
REQ-013 SHALL have port m_readdata  input  32  PIO readdata, combinational from slave, zero wait states.
REQ-014 SHALL have port verify_err  output  1  sticky readback-mismatch flag.
REQ-015 SHALL have port err_clr  input  1  synchronous clear of verify_err.

Function
REQ-016 SHALL implement FSM states IDLE, WRITE, VERIFY, GAP.
REQ-017 IDLE: if any req bit set, SHALL grant one requester, latch its wdata into a 32-bit register, record grant index, go to WRITE next cycle.
REQ-018 Arbitration SHALL be round-robin: single request wins; both requesting -> the one not granted last wins; last-grant pointer updates at each grant.
REQ-019 WRITE (exactly one cycle): m_chipselect=1, m_write_n=0, m_address=0, m_writedata=latched data.
REQ-020 VERIFY (one cycle, only when configured): m_chipselect=1, m_write_n=1, m_address=0; compare m_readdata[0] with latched data bit 0; mismatch sets verify_err at end of cycle.
REQ-021 Outside WRITE/VERIFY: m_chipselect=0, m_write_n=1, m_address=0, m_writedata=latched data.
REQ-022 ack[granted] SHALL pulse high for exactly the first cycle of GAP; other ack bit 0.
REQ-023 GAP: counter SHALL hold state for GAP_CYCLES cycles total then return to IDLE; GAP_CYCLES=0 -> ack pulse cycle is the only GAP cycle.
REQ-024 Latency (verify compiled out): req seen in IDLE at cycle N -> write strobe cycle N+1 -> ack cycle N+2; with verify: ack cycle N+3.
REQ-025 req deasserted after grant SHALL NOT abort the transaction; write and ack still occur.
REQ-026 req still high during GAP SHALL be ignored; re-evaluated only in IDLE (requester drops req on ack).
REQ-027 err_clr and mismatch in same cycle: set wins, verify_err=1.
REQ-028 m_writedata full 32 bits passed through unmodified; only bit 0 compared.

Reset
REQ-029 reset_n low SHALL asynchronously force: state IDLE, ack=0, busy=0, m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0, verify_err=0, gap counter 0, last-grant pointer=1 (req0 wins first tie).
REQ-030 Reset mid-transaction SHALL abort with no ack issued and no further bus activity.

Configuration
REQ-031 Macro PIO_ARB_VERIFY_EN defined: VERIFY state present, REQ-020 active.
REQ-032 Macro PIO_ARB_VERIFY_EN undefined: WRITE goes directly to GAP, verify_err tied 0, m_readdata and err_clr unused.

Verification
REQ-033 Single write: req=01, wdata0=0x1 -> one cycle cs=1/write_n=0/writedata=0x1, ack=01 one cycle, busy low after 4 GAP cycles.
REQ-034 Tie: req=11 from reset, wdata0=0x1, wdata1=0x0 -> req0 served first, then req1 after gap; ack order 01 then 10; next tie grants req0.
REQ-035 Gap spacing: GAP_CYCLES=4, req0 held continuously -> write strobes exactly 6 cycles apart (no verify).
REQ-036 Verify mismatch (macro on): write 0x1, slave forces m_readdata=0 in VERIFY -> verify_err=1 stays set; err_clr pulse -> 0; err_clr with simultaneous mismatch -> stays 1.
REQ-037 Reset during WRITE: reset_n low in strobe cycle -> outputs at reset values immediately, no ack; post-reset req1 served normally.

Source files
------------

// File: rtl/pio_write_arbiter.sv
// Two-requester round-robin write arbiter driving an Avalon-MM PIO slave.
// Define PIO_ARB_VERIFY_EN to add a one-cycle readback check of bit 0 after each write.
module pio_write_arbiter #(
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  req,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic [1:0]  ack,
  output logic        busy,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [1:0]  m_address,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata,
  output logic        verify_err,
  input  logic        err_clr
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WRITE  = 2'd1;
`ifdef PIO_ARB_VERIFY_EN
  localparam logic [1:0] ST_VERIFY = 2'd2;
`endif
  localparam logic [1:0] ST_GAP    = 2'd3;

  // GAP always lasts at least one cycle so the ack pulse has somewhere to live.
  localparam logic [7:0] GAP_LAST = (GAP_CYCLES <= 1) ? 8'd0 : 8'(GAP_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [31:0] data_q, data_d;
  logic        grant_q, grant_d;
  logic        last_q, last_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;
  logic        pick;

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    grant_d   = grant_q;
    last_d    = last_q;
    gap_cnt_d = gap_cnt_q;
    pick      = (req == 2'b11) ? ~last_q : req[1];
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          grant_d = pick;
          last_d  = pick;
          data_d  = pick ? wdata1 : wdata0;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
`ifdef PIO_ARB_VERIFY_EN
        state_d = ST_VERIFY;
`else
        state_d   = ST_GAP;
        gap_cnt_d = '0;
`endif
      end
`ifdef PIO_ARB_VERIFY_EN
      ST_VERIFY: begin
        state_d   = ST_GAP;
        gap_cnt_d = '0;
      end
`endif
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d   = ST_IDLE;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        gap_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      data_q    <= '0;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

`ifdef PIO_ARB_VERIFY_EN
  logic err_q, err_d;
  logic unused_rd_hi;

  // A mismatch in the same cycle as err_clr keeps the flag set.
  always_comb begin
    err_d = err_q;
    if (state_q == ST_VERIFY && (m_readdata[0] != data_q[0]))
      err_d = 1'b1;
    else if (err_clr)
      err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign verify_err   = err_q;
  assign unused_rd_hi = ^m_readdata[31:1];
  assign m_chipselect = (state_q == ST_WRITE) || (state_q == ST_VERIFY);
`else
  logic unused_verify_in;
  assign verify_err       = 1'b0;
  assign unused_verify_in = ^{m_readdata, err_clr};
  assign m_chipselect     = (state_q == ST_WRITE);
`endif

  assign busy        = (state_q != ST_IDLE);
  assign m_write_n   = (state_q != ST_WRITE);
  assign m_address   = '0;
  assign m_writedata = data_q;
  assign ack         = (state_q == ST_GAP && gap_cnt_q == 8'd0) ?
                       (grant_q ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_pio_write_arbiter.sv
// Randomized bench for pio_write_arbiter against a transaction-age reference model.
module tb_pio_write_arbiter;

  localparam int unsigned GAP = 4;
`ifdef PIO_ARB_VERIFY_EN
  localparam int V = 1;
`else
  localparam int V = 0;
`endif
  localparam int G = (GAP < 1) ? 1 : int'(GAP);

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  req = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0, m_readdata = '0;
  logic        err_clr = 1'b0;
  logic [1:0]  ack;
  logic        busy, m_chipselect, m_write_n, verify_err;
  logic [1:0]  m_address;
  logic [31:0] m_writedata;

  pio_write_arbiter #(.GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .wdata0(wdata0), .wdata1(wdata1),
    .ack(ack), .busy(busy), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
    .m_address(m_address), .m_writedata(m_writedata), .m_readdata(m_readdata),
    .verify_err(verify_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: age = cycles since grant (0 = idle).
  int          age = 0;
  bit          mgnt = 1'b0;
  bit          mlast = 1'b1;
  logic [31:0] mdata = '0;
  bit          merr = 1'b0;
  int          cyc = 0;
  int          last_wr = -1;
  logic [1:0]  ack_log[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req     = '0;
    err_clr = 1'b0;
    #1;
    check("rst_busy",    32'(busy), 32'd0);
    check("rst_ack",     32'(ack), 32'd0);
    check("rst_cs",      32'(m_chipselect), 32'd0);
    check("rst_write_n", 32'(m_write_n), 32'd1);
    check("rst_addr",    32'(m_address), 32'd0);
    check("rst_wdata",   m_writedata, 32'd0);
    check("rst_err",     32'(verify_err), 32'd0);
    age = 0; mlast = 1'b1; mgnt = 1'b0; mdata = '0; merr = 1'b0; last_wr = -1;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // mode 0: random requesters; 1: req0 held high; 2: requesters only drop on ack
  task automatic step(input int mode);
    bit ew, ev, ea;
    logic [1:0] eack;
    ew   = (age == 1);
    ev   = (V == 1) && (age == 2);
    ea   = (age == 2 + V);
    eack = ea ? (mgnt ? 2'b10 : 2'b01) : 2'b00;
    check("busy",       32'(busy), 32'(age != 0));
    check("ack",        32'(ack), 32'(eack));
    check("cs",         32'(m_chipselect), 32'(ew || ev));
    check("write_n",    32'(m_write_n), 32'(!ew));
    check("addr",       32'(m_address), 32'd0);
    check("writedata",  m_writedata, mdata);
    check("verify_err", 32'(verify_err), 32'(merr));
    if (ack != 2'b00) ack_log.push_back(ack);
    if (mode == 1 && m_write_n == 1'b0) begin
      if (last_wr >= 0) check("spacing", 32'(cyc - last_wr), 32'(2 + V + G));
      last_wr = cyc;
    end

    for (int i = 0; i < 2; i++) begin
      if (mode == 1) begin
        if (i == 0) req[0] = 1'b1;
      end else if (eack[i]) begin
        req[i] = 1'b0;
      end else if (mode == 0) begin
        if (!req[i] && $urandom_range(2) == 0) begin
          req[i] = 1'b1;
          if (i == 0) wdata0 = $urandom; else wdata1 = $urandom;
        end else if (req[i] && age != 0 && int'(mgnt) == i && $urandom_range(7) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
    m_readdata    = $urandom;
    m_readdata[0] = ($urandom_range(3) == 0) ? ~mdata[0] : mdata[0];
    err_clr       = (mode == 0) && ($urandom_range(5) == 0);

    if (V == 1) begin
      if (ev && (m_readdata[0] != mdata[0])) merr = 1'b1;
      else if (err_clr) merr = 1'b0;
    end
    if (age == 0) begin
      if (req != 2'b00) begin
        mgnt  = (req == 2'b11) ? !mlast : (req == 2'b10);
        mlast = mgnt;
        mdata = mgnt ? wdata1 : wdata0;
        age   = 1;
      end
    end else if (age == 1 + V + G) begin
      age = 0;
    end else begin
      age++;
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // single write of 0x1 from requester 0
    req = 2'b01; wdata0 = 32'h1;
    for (int i = 0; i < 4 + V + G; i++) step(2);

    // tie from reset: req0 first, then req1, then next tie goes to req0
    do_reset();
    ack_log.delete();
    req = 2'b11; wdata0 = 32'h1; wdata1 = 32'h0;
    for (int i = 0; i < 2 * (2 + V + G) + 3; i++) step(2);
    req = 2'b11; wdata0 = 32'hA5A5_0001; wdata1 = 32'h5A5A_0000;
    for (int i = 0; i < 2 + V + G + 2; i++) step(2);
    check("tie_ack_count", 32'(ack_log.size()), 32'd3);
    if (ack_log.size() >= 3) begin
      check("tie_first",  32'(ack_log[0]), 32'(2'b01));
      check("tie_second", 32'(ack_log[1]), 32'(2'b10));
      check("tie_third",  32'(ack_log[2]), 32'(2'b01));
    end
    req = 2'b00;
    for (int i = 0; i < 2 + V + G + 2; i++) step(2);

    // continuous req0: fixed strobe spacing
    do_reset();
    for (int i = 0; i < 40; i++) step(1);
    req = 2'b00;
    for (int i = 0; i < 2 + V + G + 2; i++) step(2);

    // reset in the write strobe cycle, then requester 1 served normally
    do_reset();
    req = 2'b01; wdata0 = 32'hDEAD_BEEF;
    step(2);
    check("pre_rst_strobe", 32'(m_write_n), 32'd0);
    do_reset();
    for (int i = 0; i < 3 + V + G; i++) step(2);
    req = 2'b10; wdata1 = 32'h1234_5679;
    for (int i = 0; i < 4 + V + G; i++) step(2);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) step(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
